// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: feeds an external 1-bit full adder one bit pair per
// clock, LSB first, and collects the WIDTH-bit sum plus final carry.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             adder_a,
  output logic             adder_b,
  output logic             adder_cin,
  input  logic             adder_sum,
  input  logic             adder_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  // Handshake: start is taken only while idle (busy=0); once accepted, the
  // operands are owned internally and done pulses for one cycle with sum_out/cout
  // valid. start during busy is dropped, not queued.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_next;

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at index 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next = adder_sum;
    end else begin : g_wn
      assign sum_next = {adder_sum, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    adder_a   = 1'b0;
    adder_b   = 1'b0;
    adder_cin = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        adder_a   = a_sr[0];
        adder_b   = b_sr[0];
        adder_cin = carry_r;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_r <= cin;
            cnt     <= '0;
            sum_sr  <= '0;
          end
        end
        SHIFT: begin
          sum_sr  <= sum_next;
          carry_r <= adder_cout;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + ONE;
          if (cnt == LAST) begin
            sum_out <= sum_next;
            cout    <= adder_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, each wired to a
// behavioural 1-bit full adder; results checked against a scoreboard queue.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       ad_a8, ad_b8, ad_c8, ad_s8, ad_co8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  // WIDTH=1 instance
  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       ad_a1, ad_b1, ad_c1, ad_s1, ad_co1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  assign ad_s8  = ad_a8 ^ ad_b8 ^ ad_c8;
  assign ad_co8 = (ad_a8 & ad_b8) | (ad_c8 & (ad_a8 ^ ad_b8));
  assign ad_s1  = ad_a1 ^ ad_b1 ^ ad_c1;
  assign ad_co1 = (ad_a1 & ad_b1) | (ad_c1 & (ad_a1 ^ ad_b1));

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .adder_a(ad_a8), .adder_b(ad_b8), .adder_cin(ad_c8),
    .adder_sum(ad_s8), .adder_cout(ad_co8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .adder_a(ad_a1), .adder_b(ad_b1), .adder_cin(ad_c1),
    .adder_sum(ad_s1), .adder_cout(ad_co1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] held;
  logic       done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (done_prev) check("single_done_pulse", 32'(done_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done8), 32'd0);
      end else begin
        check("result", 32'({cout8, sum8}), 32'(exp_q.pop_front()));
      end
    end
    done_prev = done8;
  end

  always @(posedge clk) begin
    if (!rst && busy8 && !done8)
      assert (!$isunknown({ad_s8, ad_co8})) else $error("X/Z on adder outputs in SHIFT");
    if (!rst)
      assert (!$isunknown({start8, start1})) else $error("X/Z on start");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
    bit         poke;
  } vec_t;

  // One add on the WIDTH=8 instance; optional start poke while busy.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input bit poke);
    bit seen = 0;
    int busy_n = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (poke && k == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      if (poke && k == 4) start8 = 1'b0;
      if (done8) begin
        check("done_latency", 32'(k), 32'd9);
        check("busy_cycles", 32'(busy_n), 32'd9);
        held = exp;
        seen = 1;
      end else begin
        check("hold", 32'({cout8, sum8}), 32'(held));
      end
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
  endtask

  function automatic logic [8:0] res_at(input int k, input logic [8:0] p,
                                        input logic [8:0] r1, input logic [8:0] r2,
                                        input logic [8:0] r3);
    if (k >= 29) return r3;
    if (k >= 19) return r2;
    if (k >= 9)  return r1;
    return p;
  endfunction

  initial begin
    vec_t vecs[4];
    logic [8:0] r1, r2, r3, p;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{a: 8'hFF, b: 8'h01, c: 1'b0, exp: 9'h100, poke: 1'b0};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, c: 1'b1, exp: 9'h100, poke: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'h01, c: 1'b0, exp: 9'h100, poke: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, c: 1'b0, exp: 9'h046, poke: 1'b0};

    // Reset with start held high: nothing may start
    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    held = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_result", 32'({cout8, sum8}), 32'd0);
      check("rst_adder", 32'({ad_a8, ad_b8, ad_c8}), 32'd0);
      check("rst_w1", 32'({busy1, done1, cout1, sum1, ad_a1, ad_b1, ad_c1}), 32'd0);
    end
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(busy8), 32'd0);

    // Table-driven adds
    for (int i = 0; i < 4; i++)
      do_add(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].poke);

    // Reset mid-operation: abort without done, outputs back to 0
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(9'h077);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    held = '0;
    @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_result", 32'({cout8, sum8}), 32'd0);
    check("midrst_adder", 32'({ad_a8, ad_b8, ad_c8}), 32'd0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done8), 32'd0);
    end
    do_add(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      do_add(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 1'b0);
    end

    // Start held continuously: accepts at edges 0, 10, 20
    p  = held;
    r1 = 9'h033 + 9'h044;
    r2 = 9'h0F0 + 9'h020 + 9'h001;
    r3 = 9'h080 + 9'h080;
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(r1);
    @(posedge clk);
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k == 1)  begin a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; exp_q.push_back(r2); end
      if (k == 11) begin a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; exp_q.push_back(r3); end
      if (k == 21) start8 = 1'b0;
      check("b2b_done", 32'(done8), 32'(k == 9 || k == 19 || k == 29));
      check("b2b_hold", 32'({cout8, sum8}), 32'(res_at(k, p, r1, r2, r3)));
    end
    repeat (4) @(negedge clk);
    check("b2b_idle", 32'(busy8), 32'd0);

    // WIDTH=1 instance: 1+1+1
    @(posedge clk); #1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(negedge clk);
    check("w1_shift_done", 32'(done1), 32'd0);
    check("w1_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    check("w1_done", 32'(done1), 32'd1);
    check("w1_result", 32'({cout1, sum1}), 32'h3);
    @(negedge clk);
    check("w1_idle", 32'({busy1, done1}), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add controller that drives the team's 1-bit full adder. It latches two WIDTH-bit operands and a carry-in, then presents one bit pair per clock, LSB first, to the external adder_1bit. It captures the adder's sum and carry_out each cycle and holds the carry between cycles in its own register. When all bits are done it returns the full WIDTH-bit sum and the final carry with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset, sampled on the rising edge of clk
start  input  1  request an add; sampled only in IDLE
a_in  input  WIDTH  operand A; latched when start is accepted
b_in  input  WIDTH  operand B; latched when start is accepted
cin  input  1  initial carry; latched when start is accepted
adder_a  output  1  to adder_1bit.a
adder_b  output  1  to adder_1bit.b
adder_cin  output  1  to adder_1bit.carry_in
adder_sum  input  1  from adder_1bit.sum
adder_cout  input  1  from adder_1bit.carry_out
busy  output  1  high while in SHIFT or DONE
done  output  1  one-cycle pulse; sum_out and cout are valid
sum_out  output  WIDTH  registered result
cout  output  1  registered final carry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. When rst is high at a rising edge, the block returns to IDLE on that edge.
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, cout=0, adder_a=adder_b=adder_cin=0. The operand shift registers, carry register and bit counter are all cleared to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: taken at an edge where start=1. On that edge:
  - a_sr<=a_in, b_sr<=b_in, carry_r<=cin, cnt<=0, sum_sr<=0.
- SHIFT:
  - adder_a=a_sr[0], adder_b=b_sr[0], adder_cin=carry_r. These are purely combinational from registers, with no logic on the path from adder_sum or adder_cout.
  - At each edge: sum_sr<={adder_sum, sum_sr[WIDTH-1:1]}, carry_r<=adder_cout, a_sr and b_sr shift right by 1 with 0 fill, cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: go to DONE. On that same edge load sum_out<={adder_sum, sum_sr[WIDTH-1:1]} and cout<=adder_cout.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Adder drive outside SHIFT: adder_a, adder_b and adder_cin are all 0 in IDLE and DONE.
- Latency: if start is accepted at edge 0, bit i is captured at edge i+1. done is high between edge WIDTH and edge WIDTH+1. Total is WIDTH+1 cycles from start to done.
- Result hold: sum_out and cout hold their value until the next operation completes. They are not cleared by start.
- start outside IDLE: ignored while in SHIFT or DONE; no queueing. Start at the edge that leaves DONE is also ignored. The earliest new accept is at edge WIDTH+2.
- Operand changes: a_in, b_in and cin may change freely after the accept edge without affecting the result.
- Reset mid-operation: the current add is aborted, no done pulse is produced, and all outputs return to their reset values at that edge.
- Counter sizing: cnt is wide enough for WIDTH-1 and must not wrap before the DONE transition.
- WIDTH=1: one SHIFT cycle, done at edge 1.
- Arithmetic: the required result is {cout,sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1).
- Bench checks: assertions fire on X/Z on adder_sum or adder_cout during SHIFT, and on X/Z on start outside reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum_out=0, cout=0, adder_* all 0; no operation starts.
- Carry ripple, WIDTH=8: a=8'hFF, b=8'h01, cin=0, start at edge 0 -> done high exactly after edge 8, sum_out=8'h00, cout=1, busy high for cycles 1..9.
- Carry-in: a=8'hA5, b=8'h5A, cin=1 -> sum_out=8'h00, cout=1. Also a=8'h12, b=8'h34, cin=0 -> sum_out=8'h46, cout=0.
- Start while busy: pulse start with a=8'h01, b=8'h01 at edge 3 of an ongoing 8'hFF+8'h01 add -> ignored. Result is 8'h00/1, one done pulse only.
- Reset mid-op: rst=1 at edge 4 of an add -> IDLE at that edge, no done pulse, sum_out=0. A following add of 8'h0F+8'h01 gives 8'h10/0.
- Back-to-back and hold: start held high continuously -> accepts at edges 0, 10 and 20. Each result is held stable between done pulses. WIDTH=1 build: 1+1+1 -> sum_out=1, cout=1, done after edge 1.
